rs_ff_bank: RTL

RS_FF_BANK -- requirements
Module: rs_ff_bank

---
 rtl/rs_ff_pkg.sv | 21 ++
 rtl/rs_ff_cell.sv | 78 +++++++
 rtl/rs_ff_bank.sv | 90 +++++++++
 3 files changed

// File: rtl/rs_ff_pkg.sv
// rs_ff_pkg
// Shared encodings for the rs_ff_bank slice:
//   mode_e       - per-bank operating mode (SR / JK / D / T)
//   inv_policy_e - SR-mode response when S and R are both high
package rs_ff_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    INV_HOLD = 2'd0,
    INV_SET  = 2'd1,
    INV_RST  = 2'd2,
    INV_TGL  = 2'd3
  } inv_policy_e;

endpackage

// File: rtl/rs_ff_cell.sv
// rs_ff_cell
// One flip-flop channel: next-state selection for SR/JK/D/T and the state
// register itself.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset, loads RESET_BIT
//   en_i    - clock enable, holds state when low
//   mode_i  - operating mode (rs_ff_pkg::mode_e encoding)
//   s_i     - S / J / D / T input
//   r_i     - R / K input (unused in D and T modes)
//   q_o     - registered state
import rs_ff_pkg::*;

module rs_ff_cell #(
  parameter logic       RESET_BIT  = 1'b0,
  parameter logic [1:0] INV_POLICY = INV_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] mode_i,
  input  logic       s_i,
  input  logic       r_i,
  output logic       q_o
);

  logic q_q;
  logic q_d;
  logic inv_d;

  // Value taken by an SR cell when S=R=1; fixed per instance.
  always_comb begin
    inv_d = q_q;
    case (INV_POLICY)
      INV_HOLD: inv_d = q_q;
      INV_SET:  inv_d = 1'b1;
      INV_RST:  inv_d = 1'b0;
      default:  inv_d = ~q_q;
    endcase
  end

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      case (mode_e'(mode_i))
        MODE_SR: begin
          case ({s_i, r_i})
            2'b10:   q_d = 1'b1;
            2'b01:   q_d = 1'b0;
            2'b11:   q_d = inv_d;
            default: q_d = q_q;
          endcase
        end
        MODE_JK: begin
          case ({s_i, r_i})
            2'b10:   q_d = 1'b1;
            2'b01:   q_d = 1'b0;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
          endcase
        end
        MODE_D:  q_d = s_i;
        MODE_T:  q_d = q_q ^ s_i;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RESET_BIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/rs_ff_bank.sv
// rs_ff_bank
// WIDTH independent flip-flop channels sharing one mode and enable, plus
// SR-mode invalid-combination tracking (sticky err and saturating inv_cnt).
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   en       - clock enable for all channels
//   mode     - 00=SR 01=JK 10=D 11=T
//   s, r     - per-channel inputs
//   clr_err  - clears err and inv_cnt (a same-cycle invalid event wins)
//   q, qn    - registered state and its complement
//   err      - sticky invalid flag
//   inv_cnt  - saturating count of cycles with an invalid SR combination
import rs_ff_pkg::*;

module rs_ff_bank #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [1:0]       INV_POLICY = INV_HOLD,
  parameter int               CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             err,
  output logic [CNT_W-1:0] inv_cnt
);

  logic             inv_evt;
  logic             err_q;
  logic             err_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    rs_ff_cell #(
      .RESET_BIT  (RESET_VAL[i]),
      .INV_POLICY (INV_POLICY)
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en),
      .mode_i (mode),
      .s_i    (s[i]),
      .r_i    (r[i]),
      .q_o    (q[i])
    );
  end

  // One event per cycle, however many channels see S=R=1.
  assign inv_evt = en && (mode_e'(mode) == MODE_SR) && (|(s & r));

  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (inv_evt) begin
      err_d = 1'b1;
      if (clr_err) begin
        // The clear empties the counter and the new event is counted on top.
        cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (clr_err) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign qn      = ~q;
  assign err     = err_q;
  assign inv_cnt = cnt_q;

endmodule
